// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback control FSM
// Optional cycle/instret counters enabled by defining PERF_COUNTER_EN.
module multicycle_sequencer #(
  parameter logic [31:0] RESET_IR    = 32'h00000013,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_reg_wren,
  input  logic        dec_ram_wren,
  input  logic        dec_reg_write_data_src,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  input  logic        dmem_resp_valid,
  output logic        reg_wren,
  output logic        pc_wren,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_MEM        = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_WRITEBACK  = 3'd6,
    S_HALT       = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_wait_cnt;
  logic        r_fault;
  logic        r_reg_wren;
  logic        r_pc_wren;
  logic        r_dmem_req_valid;
  logic        r_dmem_we;
  logic        r_halted;
  logic        w_timeout;
  logic        w_in_wait;
  logic        w_ir_load;

  assign w_in_wait = (r_state == S_FETCH_WAIT) || (r_state == S_MEM_WAIT);
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == MEM_TIMEOUT - 1);
  assign w_ir_load = imem_resp_valid &&
                     (((r_state == S_FETCH) && imem_req_ready) || (r_state == S_FETCH_WAIT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:      if (imem_req_ready) w_next = imem_resp_valid ? S_DECODE : S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (imem_resp_valid) w_next = S_DECODE;
        else if (w_timeout)  w_next = S_HALT;
      end
      S_DECODE:     w_next = S_EXECUTE;
      S_EXECUTE:    w_next = (dec_ram_wren || dec_reg_write_data_src) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        if (dmem_req_ready)
          w_next = (dec_ram_wren || dmem_resp_valid) ? S_WRITEBACK : S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (dmem_resp_valid) w_next = S_WRITEBACK;
        else if (w_timeout)  w_next = S_HALT;
      end
      S_WRITEBACK:  w_next = halt_req ? S_HALT : S_FETCH;
      S_HALT:       if (!halt_req && !r_fault) w_next = S_FETCH;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_FETCH;
      r_ir             <= RESET_IR;
      r_wait_cnt       <= '0;
      r_fault          <= 1'b0;
      r_reg_wren       <= 1'b0;
      r_pc_wren        <= 1'b0;
      r_dmem_req_valid <= 1'b0;
      r_dmem_we        <= 1'b0;
      r_halted         <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_load) r_ir <= imem_rdata;
      r_wait_cnt <= (w_in_wait && (w_next == r_state)) ? r_wait_cnt + 32'd1 : 32'd0;
      if (w_in_wait && (w_next == S_HALT)) r_fault <= 1'b1;
      r_reg_wren       <= (w_next == S_WRITEBACK) && dec_reg_wren;
      r_pc_wren        <= (w_next == S_WRITEBACK);
      r_dmem_req_valid <= (w_next == S_MEM);
      r_dmem_we        <= (w_next == S_MEM) && dec_ram_wren;
      r_halted         <= (w_next == S_HALT);
    end
  end

  // Fetch request follows the state directly so the first post-reset cycle already fetches.
  assign imem_req_valid = (r_state == S_FETCH) && rst_n;
  assign ir             = r_ir;
  assign dmem_req_valid = r_dmem_req_valid;
  assign dmem_we        = r_dmem_we;
  assign reg_wren       = r_reg_wren;
  assign pc_wren        = r_pc_wren;
  assign halted         = r_halted;
  assign fault          = r_fault;
  assign state          = r_state;

`ifdef PERF_COUNTER_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instret_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      if (r_state != S_HALT)     r_cycle_count   <= r_cycle_count + 32'd1;
      if (r_state == S_WRITEBACK) r_instret_count <= r_instret_count + 32'd1;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
`else
  assign cycle_count   = 32'd0;
  assign instret_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer
// Builds the expected per-cycle state trace from memory latencies and instruction kind.
module tb_multicycle_sequencer;

  localparam logic [2:0]  FE = 3'd0, FW = 3'd1, DE = 3'd2, EX = 3'd3;
  localparam logic [2:0]  ME = 3'd4, MW = 3'd5, WB = 3'd6, HA = 3'd7;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_rdata, ir;
  logic        dec_reg_wren, dec_ram_wren, dec_reg_write_data_src;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_resp_valid;
  logic        reg_wren, pc_wren, halt_req, halted, fault;
  logic [2:0]  state;
  logic [31:0] cycle_count, instret_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ir, m_cyc, m_ret;
  bit          m_fault, m_store, m_regw;

  always #5 clk = ~clk;

  multicycle_sequencer #(.RESET_IR(NOP), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata), .ir(ir),
    .dec_reg_wren(dec_reg_wren), .dec_ram_wren(dec_ram_wren),
    .dec_reg_write_data_src(dec_reg_write_data_src),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_resp_valid(dmem_resp_valid),
    .reg_wren(reg_wren), .pc_wren(pc_wren), .halt_req(halt_req),
    .halted(halted), .fault(fault), .state(state),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit rnd();
    return ($urandom_range(0, 1) != 0);
  endfunction

  // One clock cycle: drive inputs at the falling edge, check the expected state, advance the model.
  task automatic step(input logic [2:0] st, input bit iry, input bit irs,
                      input bit dry, input bit drs, input bit hq);
    logic [31:0] rd;
    rd = $urandom;
    imem_req_ready  = iry;
    imem_resp_valid = irs;
    imem_rdata      = rd;
    dmem_req_ready  = dry;
    dmem_resp_valid = drs;
    halt_req        = hq;
    #1;
    chk("state", {29'd0, state}, {29'd0, st});
    chk("strobes",
        {25'd0, imem_req_valid, dmem_req_valid, dmem_we, reg_wren, pc_wren, halted, fault},
        {25'd0, st == FE, st == ME, (st == ME) && m_store, (st == WB) && m_regw,
         st == WB, st == HA, m_fault});
    chk("ir", ir, m_ir);
`ifdef PERF_COUNTER_EN
    chk("cycle_count", cycle_count, m_cyc);
    chk("instret_count", instret_count, m_ret);
`else
    chk("cycle_count", cycle_count, 32'd0);
    chk("instret_count", instret_count, 32'd0);
`endif
    if (irs && (((st == FE) && iry) || (st == FW))) m_ir = rd;
    if (st != HA) m_cyc = m_cyc + 32'd1;
    if (st == WB) m_ret = m_ret + 32'd1;
    @(negedge clk);
  endtask

  // kind: 0 = ALU, 1 = store, 2 = load. fa/ma = cycles before ready, fb/mb = response delay after accept.
  task automatic do_instr(input int kind, input bit regw, input int fa, input int fb,
                          input int ma, input int mb, input bit hlt, input int hcyc);
    m_store = (kind == 1);
    m_regw  = regw;
    dec_ram_wren           = (kind == 1);
    dec_reg_write_data_src = (kind == 2);
    dec_reg_wren           = regw;
    for (int i = 0; i <= fa; i++) step(FE, i == fa, (i == fa) && (fb == 0), 1'b0, 1'b0, rnd());
    for (int j = 1; j <= fb; j++) step(FW, 1'b0, j == fb, 1'b0, 1'b0, rnd());
    step(DE, 1'b0, 1'b0, 1'b0, 1'b0, rnd());
    step(EX, 1'b0, 1'b0, 1'b0, 1'b0, hlt ? 1'b1 : rnd());
    if (kind != 0) begin
      for (int i = 0; i <= ma; i++)
        step(ME, 1'b0, 1'b0, i == ma, (kind == 2) && (mb == 0) && (i == ma), hlt ? 1'b1 : rnd());
      if (kind == 2)
        for (int j = 1; j <= mb; j++) step(MW, 1'b0, 1'b0, 1'b0, j == mb, hlt ? 1'b1 : rnd());
    end
    step(WB, 1'b0, 1'b0, 1'b0, 1'b0, hlt);
    if (hlt) begin
      for (int i = 0; i < hcyc; i++) step(HA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(HA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; released on a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_outputs", {26'd0, imem_req_valid, dmem_req_valid, dmem_we, reg_wren, pc_wren, halted},
        32'd0);
    chk("rst_ir", ir, NOP);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ir    = NOP;
    m_cyc   = 32'd0;
    m_ret   = 32'd0;
    m_fault = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = 32'd0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; halt_req = 1'b0;
    dec_reg_wren = 1'b0; dec_ram_wren = 1'b0; dec_reg_write_data_src = 1'b0;
    m_store = 1'b0; m_regw = 1'b0;
    do_reset();

    do_instr(0, 1'b1, 0, 0, 0, 0, 1'b0, 0);
    do_instr(0, 1'b1, 3, 2, 0, 0, 1'b0, 0);
    do_instr(1, 1'b0, 0, 0, 2, 0, 1'b0, 0);
    do_instr(2, 1'b1, 0, 0, 0, 4, 1'b0, 0);
    do_instr(2, 1'b1, 1, 0, 0, 0, 1'b0, 0);
    do_instr(0, 1'b1, 0, 0, 0, 0, 1'b1, 3);

    // Reset while a store request is outstanding.
    m_store = 1'b1; m_regw = 1'b0;
    dec_ram_wren = 1'b1; dec_reg_write_data_src = 1'b0; dec_reg_wren = 1'b0;
    step(FE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(DE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ME, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Instruction memory never responds: timeout after 8 wait cycles, parked despite halt_req low.
    step(FE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(FW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_fault = 1'b1;
    for (int k = 0; k < 4; k++) step(HA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int n = 0; n < 25; n++)
      do_instr($urandom_range(0, 2), rnd(), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3) == 0,
               $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
